// File: rtl/counter_monitor.sv
// Watches a free-running counter: predicts each valid sample from the previous one plus its
// increment command, and reports lock, mismatch pulses, saturating statistics and a sticky fault.
module counter_monitor #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned FAULT_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     value,
  input  logic                 increment,
  output logic                 locked,
  output logic                 mismatch,
  output logic                 fault,
  output logic [WIDTH-1:0]     expected,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic [CNT_WIDTH-1:0] wrap_count
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] LIMIT     = CNT_WIDTH'(FAULT_LIMIT);
  localparam logic [WIDTH-1:0]     VAL_ZERO  = {WIDTH{1'b0}};

  state_e                 state_q;
  logic                   inc_q;
  logic [WIDTH-1:0]       expected_q;
  logic [CNT_WIDTH-1:0]   mcount_q;
  logic [CNT_WIDTH-1:0]   wcount_q;
  logic [CNT_WIDTH-1:0]   err_q;
  logic                   locked_q;
  logic                   mismatch_q;
  logic                   fault_q;

  logic [WIDTH-1:0]       predict_d;
  logic                   hit_d;
  logic                   wrap_d;
  logic [CNT_WIDTH-1:0]   mcount_d;
  logic [CNT_WIDTH-1:0]   wcount_d;
  logic [CNT_WIDTH-1:0]   err_d;
  logic                   limit_d;

  // Prediction, comparison and saturating increments for the current sample
  always_comb begin
    predict_d = value + {{(WIDTH-1){1'b0}}, increment};
    hit_d     = (value == expected_q);
    // A correct prediction of 0 made with increment=1 can only come from an all-ones sample
    wrap_d    = hit_d && inc_q && (expected_q == VAL_ZERO);
    mcount_d  = (mcount_q == CNT_MAX) ? mcount_q : mcount_q + CNT_ONE;
    wcount_d  = (wcount_q == CNT_MAX) ? wcount_q : wcount_q + CNT_ONE;
    err_d     = (err_q == CNT_MAX) ? err_q : err_q + CNT_ONE;
    limit_d   = (err_d >= LIMIT);
  end

  // Monitor state machine with registered outputs; reset and clear share one path
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q    <= ST_UNLOCKED;
      inc_q      <= 1'b0;
      expected_q <= VAL_ZERO;
      mcount_q   <= CNT_ZERO;
      wcount_q   <= CNT_ZERO;
      err_q      <= CNT_ZERO;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      if (valid) begin
        expected_q <= predict_d;
        inc_q      <= increment;
        case (state_q)
          ST_UNLOCKED: begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
            err_q    <= CNT_ZERO;
          end
          ST_LOCKED, ST_FAULT: begin
            if (hit_d) begin
              err_q <= CNT_ZERO;
              if (wrap_d) begin
                wcount_q <= wcount_d;
              end
            end else begin
              mismatch_q <= 1'b1;
              mcount_q   <= mcount_d;
              err_q      <= err_d;
              if (limit_d) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            err_q    <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign locked         = locked_q;
  assign mismatch       = mismatch_q;
  assign fault          = fault_q;
  assign expected       = expected_q;
  assign mismatch_count = mcount_q;
  assign wrap_count     = wcount_q;

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Checker that sits on the output of a free-running counter and confirms that the counter behaves as commanded. Each valid cycle it predicts the next count from the previous sample and the previous cycle's `increment` command, then compares the prediction with the observed value. It reports lock status, mismatch pulses, saturating error and wrap statistics, and a sticky fault after repeated consecutive errors. It is instantiated in testbenches and on-chip beside the counter, sharing that counter's clock, reset and `increment` command.

## Interface
- `WIDTH`, 32: width of the observed count.
- `CNT_WIDTH`, 16: width of the `mismatch_count` and `wrap_count` statistics.
- `FAULT_LIMIT`, 4: consecutive mismatches that force FAULT. Legal range is 1 to 2^CNT_WIDTH-1.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high. Highest priority.
- `clear`  in  1: synchronous soft clear. Priority is below `reset` and above everything else.
- `valid`  in  1: `value` and `increment` are meaningful this cycle.
- `value`  in  WIDTH: observed counter output.
- `increment`  in  1: command applied to the counter this cycle. When 1 the counter advances by 1 on the next enabled cycle; when 0 it holds.
- `locked`  out  1: monitor holds a reference sample (state LOCKED or FAULT).
- `mismatch`  out  1: one-cycle pulse flagging that the sample on the previous cycle failed prediction.
- `fault`  out  1: sticky; set on entry to FAULT.
- `expected`  out  WIDTH: current prediction for the next valid sample.
- `mismatch_count`  out  CNT_WIDTH: total mismatches, saturating.
- `wrap_count`  out  CNT_WIDTH: correctly predicted wraps from all-ones to 0, saturating.

## Operation
- State machine states: UNLOCKED, LOCKED, FAULT. All outputs are registered.
- Reset values: state is UNLOCKED. `locked`, `mismatch`, `fault`, `expected`, `mismatch_count` and `wrap_count` are all 0. The internal consecutive-error counter is 0.
- `clear` produces exactly the reset state, regardless of the current state.
- Prediction rule: `expected` = last + `increment_d`, modulo 2^WIDTH.
  - last is the previous valid `value`; `increment_d` is the `increment` captured with it.
  - Wrap from all-ones to 0 is legal and is not an error.
- Cycles with `valid`=0 are ignored: no state change, no prediction update, no pulse. Gaps therefore do not advance the prediction.
- UNLOCKED, on a valid sample:
  - Load last and `increment_d` from the sample and go to LOCKED.
  - `expected` updates from the new sample.
  - No comparison is made and no mismatch is possible.
- LOCKED, on a valid sample:
  - Compare `value` with `expected`.
  - Match: clear the consecutive-error counter. If `expected`=0 and last=all-ones with `increment_d`=1, increment `wrap_count` (saturating).
  - Mismatch: pulse `mismatch`, increment `mismatch_count` (saturating) and the consecutive-error counter. Resynchronise so that last is the observed `value`.
  - When the consecutive-error counter reaches FAULT_LIMIT, go to FAULT and set `fault`.
  - Every valid sample loads last and `increment_d` from the sample, whether it matched or not.
- FAULT:
  - Tracking, comparison, `mismatch` pulses and both statistics continue exactly as in LOCKED.
  - `fault` stays 1 and the state never returns to LOCKED. Only `reset` or `clear` exits FAULT.
- Saturation: both statistics hold at 2^CNT_WIDTH-1. The consecutive-error counter also saturates.

## Timing
- A sample presented at edge N produces its `mismatch` pulse, statistic updates and new `expected` value visible after edge N, i.e. one cycle of latency.
- The sample that takes the monitor out of UNLOCKED makes `locked` read 1 one cycle later.
- The transition to FAULT and `fault`=1 appear in the same cycle as the `mismatch` pulse of the sample that reaches FAULT_LIMIT.
- `reset` or `clear` asserted in the same cycle as `valid` wins: the sample is discarded and all outputs read reset values on the next cycle.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.
- The counter's `enable` input is not observed. An enable-low cycle must be presented with `valid`=0 so that a held value is not treated as an error.

## Test plan
All scenarios use WIDTH=8, CNT_WIDTH=8, FAULT_LIMIT=4.
- Reset, then `valid`=1 with `value` 0,1,2..50 and `increment`=1 every cycle:
  - `locked`=1 from the second cycle onward.
  - `mismatch` never pulses and `mismatch_count` stays 0.
- `increment`=0 for 10 cycles with `value` held at 7 -> no mismatch and `expected`=7 throughout.
- Run from 250 through to 5 with `increment`=1 -> exactly one wrap, `wrap_count`=1, no mismatch.
- While LOCKED, inject 9 where 8 is expected, then continue 10,11 -> exactly one `mismatch` pulse, `mismatch_count`=1, tracking resumes, `fault`=0.
- Four consecutive wrong values -> four pulses, `fault`=1 on the fourth. Then feed correct values -> `fault` stays 1 until `clear`. After `clear`, all outputs are 0 and the state is UNLOCKED.
- Assert `reset` mid-stream together with `valid` -> the sample is discarded and the next cycle shows reset values. Continuous errors for 300 samples -> `mismatch_count` saturates at 255.
